matrix_keypad_scanner: RTL
==========================

MATRIX_KEYPAD_SCANNER -- requirements
Module: matrix_keypad_scanner

Interface
REQ-001 SHALL have parameter ROWS, default 4: row lines, legal 2..8.
REQ-002 SHALL have parameter COLS, default 4: column lines, legal 2..8.
REQ-003 SHALL have parameter SCAN_DIV, default 1000: clk cycles per column dwell, legal >=4.
REQ-004 SHALL have parameter DEBOUNCE_N, default 4: consecutive matching samples to accept a press or release, legal 1..15.
REQ-005 SHALL have localparam KEY_W = max(1, clog2(ROWS*COLS)).
REQ-006 clk  input  1  single clock; all logic on posedge clk.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 row_in  input  ROWS  keypad rows, active-low, asynchronous to clk.
REQ-009 col_out  output  COLS  column drive, active-low, exactly one bit low at all times.
REQ-010 key_code  output  KEY_W  code of last accepted key, stable between key_valid pulses.
REQ-011 key_valid  output  1  one-cycle pulse when key_code is updated or repeated.
REQ-012 key_held  output  1  level, high while an accepted key is down.
REQ-013 multi_key  output  1  one-cycle pulse when more than one row is low in a sample.

Function
REQ-014 row_in SHALL pass through a 2-flop synchroniser; samples use the synchronised value.
REQ-015 Column index col_idx SHALL drive col_out = ~(1<<col_idx); a sample SHALL be taken on the last cycle of each SCAN_DIV dwell.
REQ-016 Key code SHALL be col_idx*ROWS + row_idx, row_idx = index of the single low row bit.
REQ-017 FSM states SHALL be SCAN, DEBOUNCE, HELD, RELEASE.
REQ-018 SCAN: sample all-ones -> col_idx advances, wrapping COLS-1 -> 0; exactly one low row -> capture candidate, count=1, freeze col_idx, go DEBOUNCE (DEBOUNCE_N=1 goes straight to accept).
REQ-019 SCAN/DEBOUNCE: two or more rows low -> multi_key pulse, candidate discarded, return to SCAN, col_idx advances.
REQ-020 DEBOUNCE: each sample equal to candidate increments count; mismatch or all-ones -> SCAN with col_idx advancing.
REQ-021 When count reaches DEBOUNCE_N, next cycle SHALL load key_code, pulse key_valid, set key_held, enter HELD.
REQ-022 HELD: all-ones sample -> RELEASE with release count=1; otherwise stay, col_idx frozen.
REQ-023 RELEASE: all-ones increments count; any low row -> back to HELD, no new key_valid; count=DEBOUNCE_N -> clear key_held, enter SCAN, col_idx advances.
REQ-024 key_valid and multi_key SHALL never assert in the same cycle; at most one key_valid per accepted press (except REQ-029).
REQ-025 Dwell counter width SHALL be clog2(SCAN_DIV); counters SHALL not overflow (saturate at limit).

Reset
REQ-026 While reset is high: state=SCAN, col_idx=0, col_out=~1 (column 0 low), key_code=0, key_valid=0, key_held=0, multi_key=0, all counters and synchroniser flops 0/idle (synchroniser to all-ones).
REQ-027 Reset mid-press SHALL discard all progress; no key_valid during or in the cycle after reset release.

Configuration
REQ-028 Macro KEYPAD_AUTOREPEAT_EN SHALL add parameters REPEAT_DELAY (default 500) and REPEAT_RATE (default 100), both in samples.
REQ-029 With KEYPAD_AUTOREPEAT_EN: in HELD, after REPEAT_DELAY consecutive held samples key_valid pulses with unchanged key_code, then every REPEAT_RATE samples; counter clears on entering HELD from DEBOUNCE and holds through RELEASE-to-HELD bounces.
REQ-030 Without KEYPAD_AUTOREPEAT_EN: no repeat logic or parameters; exactly one key_valid per press.

Verification (ROWS=4, COLS=4, SCAN_DIV=4, DEBOUNCE_N=3)
REQ-031 Hold row1 low while col_out=4'b1011 for 200 cycles, then release -> one key_valid, key_code=9, key_held high until 3 all-ones samples after release.
REQ-032 Row0 low on column 0 for 2 samples then high -> no key_valid, scanning resumes at column 1.
REQ-033 row_in=4'b1100 during column 1 dwell -> multi_key pulse, no key_valid, key_code unchanged.
REQ-034 Reset asserted in DEBOUNCE -> all outputs at reset values, col_out=4'b1110, no key_valid after release.
REQ-035 Held key released 1 sample then re-pressed -> key_held stays high, no second key_valid.
REQ-036 KEYPAD_AUTOREPEAT_EN, REPEAT_DELAY=8, REPEAT_RATE=2, hold 20 samples -> key_valid at acceptance, held samples 8, 10, 12, 14, 16, 18, 20.

Source files
------------

// File: rtl/matrix_keypad_scanner.sv
`timescale 1ns/1ps
// Matrix keypad scanner: column scan, 2-flop row sync, debounce, key events.
// Optional macro KEYPAD_AUTOREPEAT_EN adds typematic repeat of a held key.
module matrix_keypad_scanner #(
   parameter int ROWS       = 4,
   parameter int COLS       = 4,
   parameter int SCAN_DIV   = 1000,
   parameter int DEBOUNCE_N = 4,
`ifdef KEYPAD_AUTOREPEAT_EN
   parameter int REPEAT_DELAY = 500,
   parameter int REPEAT_RATE  = 100,
`endif
   localparam int KEY_W =
      ($clog2(ROWS*COLS) < 1) ? 1 : $clog2(ROWS*COLS)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [ROWS-1:0]  row_in,
   output logic [COLS-1:0]  col_out,
   output logic [KEY_W-1:0] key_code,
   output logic             key_valid,
   output logic             key_held,
   output logic             multi_key
);

   localparam int DIV_W  = $clog2(SCAN_DIV);
   localparam int CIDX_W = $clog2(COLS);
   localparam int RIDX_W = $clog2(ROWS);

   typedef enum logic [1:0] {
      SCAN, DEBOUNCE, HELD, RELEASE
   } state_t;

   state_t state, state_n;

   logic [ROWS-1:0]   sync1, sync2;
   logic [DIV_W-1:0]  div_cnt;
   logic              tick;
   logic [CIDX_W-1:0] col_idx, col_n, col_inc;
   logic [3:0]        cnt, cnt_n;
   logic [KEY_W-1:0]  cand, cand_n, code_n, code_now;
   logic              valid_n, held_n, multi_n;
   logic [3:0]        n_low;
   logic [RIDX_W-1:0] row_idx;
   logic              acc, adv;

`ifdef KEYPAD_AUTOREPEAT_EN
   localparam int RPT_W = $clog2(REPEAT_DELAY + 1);
   localparam int RPT_BACK =
      (REPEAT_RATE >= REPEAT_DELAY) ? 0 : REPEAT_DELAY - REPEAT_RATE;
   logic [RPT_W-1:0] rpt_cnt, rpt_n;
`endif

   assign tick    = (div_cnt == DIV_W'(SCAN_DIV - 1));
   assign col_out = ~(COLS'(1) << col_idx);
   assign col_inc = (col_idx == CIDX_W'(COLS - 1)) ? '0 : col_idx + 1'b1;
   assign code_now = KEY_W'(int'(col_idx) * ROWS + int'(row_idx));

   // Bring the asynchronous rows into the clock domain; idle is all-ones.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1 <= '1;
         sync2 <= '1;
      end else begin
         sync1 <= row_in;
         sync2 <= sync1;
      end
   end

   // Column dwell timer; the last cycle of each dwell is the sample point.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) div_cnt <= '0;
      else if (tick) div_cnt <= '0;
      else div_cnt <= div_cnt + 1'b1;
   end

   // Count low rows and locate the (lowest) low row in the sample.
   always_comb begin
      n_low   = '0;
      row_idx = '0;
      for (int r = ROWS - 1; r >= 0; r--) begin
         if (!sync2[r]) begin
            n_low   = n_low + 4'd1;
            row_idx = RIDX_W'(r);
         end
      end
   end

   // Scan/debounce/hold/release decisions, evaluated on sample ticks.
   always_comb begin
      state_n = state;
      col_n   = col_idx;
      cnt_n   = cnt;
      cand_n  = cand;
      code_n  = key_code;
      valid_n = 1'b0;
      held_n  = key_held;
      multi_n = 1'b0;
      acc     = 1'b0;
      adv     = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rpt_n   = rpt_cnt;
`endif
      if (tick) begin
         unique case (state)
            SCAN: begin
               if (n_low > 4'd1) begin
                  multi_n = 1'b1;
                  adv     = 1'b1;
               end else if (n_low == 4'd1) begin
                  cand_n = code_now;
                  if (DEBOUNCE_N == 1) acc = 1'b1;
                  else begin
                     cnt_n   = 4'd1;
                     state_n = DEBOUNCE;
                  end
               end else begin
                  adv = 1'b1;
               end
            end
            DEBOUNCE: begin
               if (n_low > 4'd1) begin
                  multi_n = 1'b1;
                  adv     = 1'b1;
               end else if (n_low == 4'd1 && code_now == cand) begin
                  if (cnt + 4'd1 == 4'(DEBOUNCE_N)) acc = 1'b1;
                  else cnt_n = cnt + 4'd1;
               end else begin
                  adv = 1'b1;
               end
            end
            HELD: begin
               if (n_low == 4'd0) begin
                  if (DEBOUNCE_N == 1) begin
                     held_n = 1'b0;
                     adv    = 1'b1;
                  end else begin
                     cnt_n   = 4'd1;
                     state_n = RELEASE;
                  end
               end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
                  if (int'(rpt_cnt) + 1 == REPEAT_DELAY) begin
                     valid_n = 1'b1;
                     rpt_n   = RPT_W'(RPT_BACK);
                  end else begin
                     rpt_n = rpt_cnt + 1'b1;
                  end
`endif
               end
            end
            RELEASE: begin
               if (n_low == 4'd0) begin
                  if (cnt + 4'd1 == 4'(DEBOUNCE_N)) begin
                     held_n = 1'b0;
                     adv    = 1'b1;
                  end else begin
                     cnt_n = cnt + 4'd1;
                  end
               end else begin
                  cnt_n   = 4'd0;
                  state_n = HELD;
               end
            end
         endcase
      end
      if (adv) begin
         state_n = SCAN;
         col_n   = col_inc;
         cnt_n   = 4'd0;
      end
      if (acc) begin
         state_n = HELD;
         code_n  = code_now;
         valid_n = 1'b1;
         held_n  = 1'b1;
         cnt_n   = 4'd0;
`ifdef KEYPAD_AUTOREPEAT_EN
         rpt_n   = '0;
`endif
      end
   end

   // State and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= SCAN;
         col_idx   <= '0;
         cnt       <= '0;
         cand      <= '0;
         key_code  <= '0;
         key_valid <= 1'b0;
         key_held  <= 1'b0;
         multi_key <= 1'b0;
      end else begin
         state     <= state_n;
         col_idx   <= col_n;
         cnt       <= cnt_n;
         cand      <= cand_n;
         key_code  <= code_n;
         key_valid <= valid_n;
         key_held  <= held_n;
         multi_key <= multi_n;
      end
   end

`ifdef KEYPAD_AUTOREPEAT_EN
   // Held-sample counter for auto-repeat.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) rpt_cnt <= '0;
      else rpt_cnt <= rpt_n;
   end
`endif

endmodule
